// File: rtl/pcm_bffr_pkg.sv
// Shared types and default frame geometry for the PCM ping-pong buffer manager.
package pcm_bffr_pkg;

  typedef enum logic {
    HOST_EMPTY = 1'b0,
    HOST_READY = 1'b1
  } host_state_e;

  localparam int unsigned PCM_DATA_W_DFLT = 32;
  localparam int unsigned PCM_ADDR_W_DFLT = 8;
  localparam int unsigned PCM_NUM_SAMPLES = 128;
  localparam int unsigned PCM_RD_DEL_DFLT = 2;
  localparam int unsigned OVRFLW_CNT_W    = 16;

endpackage

// File: rtl/pcm_dp_ram.sv
// Dual-port synchronous RAM: port A write-only (audio), port B read/write (host)
// with RD_DEL cycles of read latency; only the output pipeline is reset.
module pcm_dp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_DEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_re,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned PIPE_N = RD_DEL - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_pipe [PIPE_N];

  // Array core: no reset, contents undefined until written
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    if (b_re) rd_q <= mem[b_addr];
  end

  // Output delay stages bring total read latency to RD_DEL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PIPE_N); i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= rd_q;
      for (int i = 1; i < int'(PIPE_N); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign b_rdata = rd_pipe[PIPE_N-1];

endmodule

// File: rtl/pcm_bffr_mgr.sv
// PCM capture buffer manager: fills one bank of a ping-pong frame store from
// the audio stream while the host reads/releases the other bank.
module pcm_bffr_mgr
  import pcm_bffr_pkg::*;
#(
  parameter int unsigned PCM_MEM_DATA_W = PCM_DATA_W_DFLT,
  parameter int unsigned PCM_MEM_ADDR_W = PCM_ADDR_W_DFLT,
  parameter int unsigned NUM_SAMPLES    = PCM_NUM_SAMPLES,
  parameter int unsigned MEM_RD_DEL     = PCM_RD_DEL_DFLT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      capture_en,
  input  logic                      aud_valid,
  input  logic                      aud_chnnl,
  input  logic [PCM_MEM_DATA_W-1:0] aud_data,
  output logic                      pcm_rdy,
  input  logic [PCM_MEM_ADDR_W-1:0] pcm_addr,
  input  logic [PCM_MEM_DATA_W-1:0] pcm_wdata,
  input  logic                      pcm_wren,
  input  logic                      pcm_rden,
  output logic [PCM_MEM_DATA_W-1:0] pcm_rdata,
  output logic                      pcm_rd_valid,
  output logic                      bffr_ovrflw,
  output logic [OVRFLW_CNT_W-1:0]   ovrflw_cnt,
  output logic                      chnnl_skew
);

  localparam int unsigned IDX_W  = $clog2(NUM_SAMPLES);
  localparam int unsigned CNT_W  = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned RAM_AW = IDX_W + 2;
  localparam logic [CNT_W-1:0]          FULL_CNT   = CNT_W'(NUM_SAMPLES);
  localparam logic [PCM_MEM_ADDR_W-1:0] LAST_ADDR  = PCM_MEM_ADDR_W'(2 * NUM_SAMPLES - 1);
  localparam logic [OVRFLW_CNT_W-1:0]   OVRFLW_MAX = '1;

  host_state_e          state_q, state_nxt;
  logic                 fill_bank_q, fill_bank_nxt;
  logic [CNT_W-1:0]     lcnt_q, rcnt_q;
  logic [MEM_RD_DEL-1:0] rd_vld_q;
  logic                 commit_c, drop_c;

  // Audio side decode
  logic             aud_hit_c, aud_we_c, skew_hit_c, frame_done_c;
  logic [CNT_W-1:0] ch_cnt_c;
  logic [RAM_AW-1:0] aud_addr_c;

  assign aud_hit_c    = capture_en & aud_valid;
  assign ch_cnt_c     = aud_chnnl ? rcnt_q : lcnt_q;
  assign aud_we_c     = aud_hit_c & (ch_cnt_c != FULL_CNT);
  assign skew_hit_c   = aud_hit_c & (ch_cnt_c == FULL_CNT);
  assign frame_done_c = (lcnt_q == FULL_CNT) & (rcnt_q == FULL_CNT);
  assign aud_addr_c   = {fill_bank_q, aud_chnnl, IDX_W'(ch_cnt_c)};

  // Host side decode; simultaneous read and write strobes cancel each other
  logic              host_rd_c, host_wr_c, release_c;
  logic [RAM_AW-1:0] host_addr_c;

  assign host_rd_c   = pcm_rden & ~pcm_wren;
  assign host_wr_c   = pcm_wren & ~pcm_rden;
  assign release_c   = host_wr_c & (pcm_addr == LAST_ADDR);
  assign host_addr_c = {~fill_bank_q, (IDX_W + 1)'(pcm_addr)};

  // Host bank FSM: release is applied before judging a completing frame
  always_comb begin
    state_nxt     = state_q;
    fill_bank_nxt = fill_bank_q;
    commit_c      = 1'b0;
    drop_c        = 1'b0;
    if (release_c) state_nxt = HOST_EMPTY;
    if (frame_done_c) begin
      if (state_nxt == HOST_EMPTY) begin
        commit_c      = 1'b1;
        state_nxt     = HOST_READY;
        fill_bank_nxt = ~fill_bank_q;
      end else begin
        drop_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOST_EMPTY;
      fill_bank_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      fill_bank_q <= fill_bank_nxt;
    end
  end

  // Fill counters: cleared on capture abort or once a frame is resolved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      rcnt_q <= '0;
    end else if (!capture_en || frame_done_c) begin
      lcnt_q <= '0;
      rcnt_q <= '0;
    end else if (aud_we_c) begin
      if (aud_chnnl) rcnt_q <= rcnt_q + CNT_W'(1);
      else           lcnt_q <= lcnt_q + CNT_W'(1);
    end
  end

  // Status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bffr_ovrflw <= 1'b0;
      ovrflw_cnt  <= '0;
      chnnl_skew  <= 1'b0;
      rd_vld_q    <= '0;
    end else begin
      bffr_ovrflw <= drop_c;
      if (drop_c && ovrflw_cnt != OVRFLW_MAX) ovrflw_cnt <= ovrflw_cnt + OVRFLW_CNT_W'(1);
      if (skew_hit_c) chnnl_skew <= 1'b1;
      rd_vld_q <= {rd_vld_q[MEM_RD_DEL-2:0], host_rd_c};
    end
  end

  assign pcm_rdy      = (state_q == HOST_READY);
  assign pcm_rd_valid = rd_vld_q[MEM_RD_DEL-1];

  pcm_dp_ram #(
    .DATA_W (PCM_MEM_DATA_W),
    .ADDR_W (RAM_AW),
    .RD_DEL (MEM_RD_DEL)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_we    (aud_we_c),
    .a_addr  (aud_addr_c),
    .a_wdata (aud_data),
    .b_re    (host_rd_c),
    .b_we    (host_wr_c),
    .b_addr  (host_addr_c),
    .b_wdata (pcm_wdata),
    .b_rdata (pcm_rdata)
  );

endmodule

// File: tb/tb_pcm_bffr_mgr.sv
// Directed self-checking bench for pcm_bffr_mgr with default parameters.
module tb_pcm_bffr_mgr;

  logic        clk;
  logic        rst_n;
  logic        capture_en;
  logic        aud_valid;
  logic        aud_chnnl;
  logic [31:0] aud_data;
  logic        pcm_rdy;
  logic [7:0]  pcm_addr;
  logic [31:0] pcm_wdata;
  logic        pcm_wren;
  logic        pcm_rden;
  logic [31:0] pcm_rdata;
  logic        pcm_rd_valid;
  logic        bffr_ovrflw;
  logic [15:0] ovrflw_cnt;
  logic        chnnl_skew;

  int errors = 0;
  int checks = 0;
  int ovf_pulses = 0;
  logic [31:0] rd;
  logic va, vb, vc;

  pcm_bffr_mgr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_en   (capture_en),
    .aud_valid    (aud_valid),
    .aud_chnnl    (aud_chnnl),
    .aud_data     (aud_data),
    .pcm_rdy      (pcm_rdy),
    .pcm_addr     (pcm_addr),
    .pcm_wdata    (pcm_wdata),
    .pcm_wren     (pcm_wren),
    .pcm_rden     (pcm_rden),
    .pcm_rdata    (pcm_rdata),
    .pcm_rd_valid (pcm_rd_valid),
    .bffr_ovrflw  (bffr_ovrflw),
    .ovrflw_cnt   (ovrflw_cnt),
    .chnnl_skew   (chnnl_skew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && bffr_ovrflw) ovf_pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ch, input logic [31:0] d);
    aud_valid = 1'b1;
    aud_chnnl = ch;
    aud_data  = d;
    step();
    aud_valid = 1'b0;
  endtask

  task automatic fill_pairs(input int n, input logic [31:0] bl, input logic [31:0] br);
    for (int i = 0; i < n; i++) begin
      push(1'b0, bl + 32'(i));
      push(1'b1, br + 32'(i));
    end
  endtask

  task automatic fill_frame(input logic [31:0] bl, input logic [31:0] br);
    fill_pairs(128, bl, br);
    step();
    step();
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    pcm_wren  = 1'b1;
    pcm_addr  = a;
    pcm_wdata = d;
    step();
    pcm_wren  = 1'b0;
  endtask

  // Single read; returns valid as seen 1, 2 and 3 cycles after the strobe
  task automatic host_read(input logic [7:0] a, output logic [31:0] d,
                           output logic v1, output logic v2, output logic v3);
    pcm_rden = 1'b1;
    pcm_addr = a;
    step();
    pcm_rden = 1'b0;
    v1 = pcm_rd_valid;
    step();
    v2 = pcm_rd_valid;
    d  = pcm_rdata;
    step();
    v3 = pcm_rd_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({pcm_rdy, pcm_rd_valid, bffr_ovrflw, chnnl_skew} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {pcm_rdy, pcm_rd_valid, bffr_ovrflw, chnnl_skew});
    end
    checks++;
    if (pcm_rdata !== 32'h0 || ovrflw_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h cnt=%h expected 0/0", pcm_rdata, ovrflw_cnt);
    end
    rst_n = 1'b1;
    capture_en = 1'b1;
    step();
    // reset asserted while a read is in flight
    pcm_rden = 1'b1;
    pcm_addr = 8'd0;
    step();
    pcm_rden = 1'b0;
    rst_n = 1'b0;
    #1;
    step();
    checks++;
    if (pcm_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got valid=%b expected 0", pcm_rd_valid);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (pcm_rd_valid !== 1'b0 || pcm_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_read: got valid=%b rdy=%b expected 0 0", pcm_rd_valid, pcm_rdy);
    end
  endtask

  task automatic test_nominal();
    fill_frame(32'h0, 32'h1000);
    checks++;
    if (pcm_rdy !== 1'b1 || ovrflw_cnt !== 16'd0 || chnnl_skew !== 1'b0) begin
      errors++;
      $display("FAIL nom_status: got rdy=%b cnt=%0d skew=%b expected 1 0 0", pcm_rdy, ovrflw_cnt, chnnl_skew);
    end
    host_read(8'd5, rd, va, vb, vc);
    checks++;
    if ({va, vb, vc} !== 3'b010) begin
      errors++;
      $display("FAIL nom_rd5_timing: got %b%b%b expected 010", va, vb, vc);
    end
    checks++;
    if (rd !== 32'd5) begin
      errors++;
      $display("FAIL nom_rd5_data: got %h expected %h", rd, 32'd5);
    end
    host_read(8'd133, rd, va, vb, vc);
    checks++;
    if ({va, vb, vc} !== 3'b010 || rd !== 32'h1005) begin
      errors++;
      $display("FAIL nom_rd133: got v=%b%b%b d=%h expected 010 00001005", va, vb, vc, rd);
    end
  endtask

  task automatic test_back_to_back();
    pcm_rden = 1'b1;
    pcm_addr = 8'd0;
    step();
    checks++;
    if (pcm_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c1: got valid=%b expected 0", pcm_rd_valid);
    end
    pcm_addr = 8'd128;
    step();
    checks++;
    if (pcm_rd_valid !== 1'b1 || pcm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_c2: got v=%b d=%h expected 1 00000000", pcm_rd_valid, pcm_rdata);
    end
    pcm_addr = 8'd127;
    step();
    pcm_rden = 1'b0;
    checks++;
    if (pcm_rd_valid !== 1'b1 || pcm_rdata !== 32'h1000) begin
      errors++;
      $display("FAIL b2b_c3: got v=%b d=%h expected 1 00001000", pcm_rd_valid, pcm_rdata);
    end
    step();
    checks++;
    if (pcm_rd_valid !== 1'b1 || pcm_rdata !== 32'h7f) begin
      errors++;
      $display("FAIL b2b_c4: got v=%b d=%h expected 1 0000007f", pcm_rd_valid, pcm_rdata);
    end
    step();
    checks++;
    if (pcm_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c5: got valid=%b expected 0", pcm_rd_valid);
    end
  endtask

  task automatic test_rw_conflict();
    pcm_rden  = 1'b1;
    pcm_wren  = 1'b1;
    pcm_addr  = 8'd255;
    pcm_wdata = 32'hdead;
    step();
    pcm_rden = 1'b0;
    pcm_wren = 1'b0;
    checks++;
    if (pcm_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rw_no_release: got rdy=%b expected 1", pcm_rdy);
    end
    step();
    checks++;
    if (pcm_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_no_read: got valid=%b expected 0", pcm_rd_valid);
    end
    host_read(8'd255, rd, va, vb, vc);
    checks++;
    if (rd !== 32'h107f) begin
      errors++;
      $display("FAIL rw_no_write: got %h expected 0000107f", rd);
    end
  endtask

  task automatic test_overflow();
    int p0;
    p0 = ovf_pulses;
    fill_frame(32'h2000, 32'h3000);
    checks++;
    if (ovf_pulses - p0 !== 1 || ovrflw_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ovf_count: got pulses=%0d cnt=%0d expected 1 1", ovf_pulses - p0, ovrflw_cnt);
    end
    checks++;
    if (pcm_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_rdy: got %b expected 1", pcm_rdy);
    end
    host_read(8'd5, rd, va, vb, vc);
    checks++;
    if (rd !== 32'd5) begin
      errors++;
      $display("FAIL ovf_intact5: got %h expected 00000005", rd);
    end
    host_read(8'd200, rd, va, vb, vc);
    checks++;
    if (rd !== 32'h1048) begin
      errors++;
      $display("FAIL ovf_intact200: got %h expected 00001048", rd);
    end
  endtask

  task automatic test_release();
    host_write(8'd255, 32'habcd);
    checks++;
    if (pcm_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rel_rdy_fall: got %b expected 0", pcm_rdy);
    end
    host_read(8'd255, rd, va, vb, vc);
    checks++;
    if ({va, vb, vc} !== 3'b010 || rd !== 32'habcd) begin
      errors++;
      $display("FAIL rel_stale_read: got v=%b%b%b d=%h expected 010 0000abcd", va, vb, vc, rd);
    end
    fill_frame(32'h4000, 32'h5000);
    checks++;
    if (pcm_rdy !== 1'b1 || ovrflw_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rel_recommit: got rdy=%b cnt=%0d expected 1 1", pcm_rdy, ovrflw_cnt);
    end
    host_read(8'd0, rd, va, vb, vc);
    checks++;
    if (rd !== 32'h4000) begin
      errors++;
      $display("FAIL rel_new_rd0: got %h expected 00004000", rd);
    end
    host_read(8'd128, rd, va, vb, vc);
    checks++;
    if (rd !== 32'h5000) begin
      errors++;
      $display("FAIL rel_new_rd128: got %h expected 00005000", rd);
    end
  endtask

  task automatic test_skew();
    host_write(8'd255, 32'h0);
    checks++;
    if (pcm_rdy !== 1'b0 || chnnl_skew !== 1'b0) begin
      errors++;
      $display("FAIL skew_pre: got rdy=%b skew=%b expected 0 0", pcm_rdy, chnnl_skew);
    end
    for (int i = 0; i < 129; i++) push(1'b0, 32'h6000 + 32'(i));
    step();
    step();
    checks++;
    if (chnnl_skew !== 1'b1 || pcm_rdy !== 1'b0) begin
      errors++;
      $display("FAIL skew_flag: got skew=%b rdy=%b expected 1 0", chnnl_skew, pcm_rdy);
    end
    for (int i = 0; i < 128; i++) push(1'b1, 32'h7000 + 32'(i));
    step();
    step();
    checks++;
    if (pcm_rdy !== 1'b1) begin
      errors++;
      $display("FAIL skew_commit: got rdy=%b expected 1", pcm_rdy);
    end
    host_read(8'd127, rd, va, vb, vc);
    checks++;
    if (rd !== 32'h607f) begin
      errors++;
      $display("FAIL skew_rd127: got %h expected 0000607f", rd);
    end
    host_read(8'd128, rd, va, vb, vc);
    checks++;
    if (rd !== 32'h7000) begin
      errors++;
      $display("FAIL skew_rd128: got %h expected 00007000", rd);
    end
  endtask

  task automatic test_abort();
    host_write(8'd255, 32'h0);
    fill_pairs(64, 32'h8000, 32'h9000);
    capture_en = 1'b0;
    push(1'b0, 32'heeee);
    step();
    capture_en = 1'b1;
    checks++;
    if (pcm_rdy !== 1'b0) begin
      errors++;
      $display("FAIL abort_rdy: got %b expected 0", pcm_rdy);
    end
    fill_frame(32'ha000, 32'hb000);
    checks++;
    if (pcm_rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_commit: got rdy=%b expected 1", pcm_rdy);
    end
    host_read(8'd0, rd, va, vb, vc);
    checks++;
    if (rd !== 32'ha000) begin
      errors++;
      $display("FAIL abort_rd0: got %h expected 0000a000", rd);
    end
    host_read(8'd191, rd, va, vb, vc);
    checks++;
    if (rd !== 32'hb03f) begin
      errors++;
      $display("FAIL abort_rd191: got %h expected 0000b03f", rd);
    end
  endtask

  task automatic test_collision();
    int p0;
    p0 = ovf_pulses;
    fill_pairs(128, 32'hc000, 32'hd000);
    host_write(8'd255, 32'h5555);
    checks++;
    if (pcm_rdy !== 1'b1) begin
      errors++;
      $display("FAIL coll_rdy: got %b expected 1", pcm_rdy);
    end
    step();
    checks++;
    if (pcm_rdy !== 1'b1 || ovrflw_cnt !== 16'd1 || ovf_pulses !== p0) begin
      errors++;
      $display("FAIL coll_no_ovf: got rdy=%b cnt=%0d pulses=%0d expected 1 1 %0d",
               pcm_rdy, ovrflw_cnt, ovf_pulses, p0);
    end
    host_read(8'd0, rd, va, vb, vc);
    checks++;
    if (rd !== 32'hc000) begin
      errors++;
      $display("FAIL coll_rd0: got %h expected 0000c000", rd);
    end
    host_read(8'd255, rd, va, vb, vc);
    checks++;
    if (rd !== 32'hd07f) begin
      errors++;
      $display("FAIL coll_rd255: got %h expected 0000d07f", rd);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    capture_en = 1'b0;
    aud_valid  = 1'b0;
    aud_chnnl  = 1'b0;
    aud_data   = '0;
    pcm_addr   = '0;
    pcm_wdata  = '0;
    pcm_wren   = 1'b0;
    pcm_rden   = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_rw_conflict();
    test_overflow();
    test_release();
    test_skew();
    test_abort();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcm_bffr_mgr.md
PCM_BFFR_MGR -- requirements
Module: pcm_bffr_mgr

Interface
REQ-001 SHALL have parameter PCM_MEM_DATA_W, default 32, meaning the sample and RAM word width.
REQ-002 SHALL have parameter PCM_MEM_ADDR_W, default 8, meaning the host address width; one frame is 2*NUM_SAMPLES words.
REQ-003 SHALL have parameter NUM_SAMPLES, default 128, meaning samples per channel per frame.
REQ-004 SHALL have parameter MEM_RD_DEL, default 2, meaning host read latency in cycles, minimum 2.
REQ-005 SHALL have these ports, as name, direction, width and meaning:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- capture_en  in  1  enables audio capture.
- aud_valid  in  1  audio sample strobe.
- aud_chnnl  in  1  channel select; 0 = left, 1 = right.
- aud_data  in  PCM_MEM_DATA_W  audio sample.
- pcm_rdy  out  1  a committed frame is available to the host.
- pcm_addr  in  PCM_MEM_ADDR_W  host address.
- pcm_wdata  in  PCM_MEM_DATA_W  host write data.
- pcm_wren  in  1  host write strobe.
- pcm_rden  in  1  host read strobe.
- pcm_rdata  out  PCM_MEM_DATA_W  host read data.
- pcm_rd_valid  out  1  qualifies pcm_rdata.
- bffr_ovrflw  out  1  one-cycle pulse on a dropped frame.
- ovrflw_cnt  out  16  saturating count of dropped frames.
- chnnl_skew  out  1  sticky flag: a sample arrived for an already-full channel.

Function
REQ-006 SHALL hold two frame banks (ping-pong) in one true dual-port RAM of depth 4*NUM_SAMPLES.
- Port A: audio writes.
- Port B: host access.
REQ-007 SHALL map frame words as follows:
- Left sample i at host address i.
- Right sample i at host address NUM_SAMPLES+i.
- Internal address = {bank, aud_chnnl, idx}.
REQ-008 SHALL keep per-channel fill counters lcnt and rcnt, each ranging 0..NUM_SAMPLES, plus a fill_bank bit.
REQ-009 SHALL, on aud_valid and capture_en with the addressed channel count < NUM_SAMPLES:
- write aud_data to the fill bank at the channel's count;
- increment that count.
REQ-010 SHALL drop a sample arriving for a channel whose count equals NUM_SAMPLES, and set chnnl_skew.
REQ-011 SHALL treat the cycle after the write that makes lcnt = rcnt = NUM_SAMPLES as frame completion.
REQ-012 SHALL act on frame completion according to host bank state:
- EMPTY: commit the frame. Toggle fill_bank, clear lcnt and rcnt, move to READY.
- READY: drop the frame. Clear lcnt and rcnt, keep fill_bank, pulse bffr_ovrflw, increment ovrflw_cnt (saturating at 0xFFFF).
REQ-013 SHALL run the host bank FSM with two states, EMPTY and READY.
- EMPTY -> READY on commit.
- READY -> EMPTY on release.
- pcm_rdy = (state == READY).
REQ-014 SHALL serve host reads from bank ~fill_bank; pcm_rdata and pcm_rd_valid appear exactly MEM_RD_DEL cycles after pcm_rden.
REQ-015 SHALL accept back-to-back host reads one per cycle, with pcm_rd_valid following the pcm_rden pattern delayed by MEM_RD_DEL.
REQ-016 SHALL serve host reads while EMPTY with stale data and normal pcm_rd_valid timing.
REQ-017 SHALL handle host writes as follows:
- pcm_wren stores pcm_wdata into bank ~fill_bank at pcm_addr.
- A write to address 2*NUM_SAMPLES-1 additionally releases the frame.
REQ-018 SHALL give simultaneous release and frame completion release priority: the state goes EMPTY and then commits in the same cycle, ending READY with no overflow.
REQ-019 SHALL ignore pcm_rden and pcm_wren asserted together; neither a read nor a write occurs.
REQ-020 SHALL handle capture_en low as follows:
- ignore aud_valid;
- clear lcnt and rcnt (partial frame discarded);
- leave the host bank state unaffected.

Reset
REQ-021 SHALL on rst_n low drive or set:
- pcm_rdy = 0, pcm_rd_valid = 0, pcm_rdata = 0;
- bffr_ovrflw = 0, ovrflw_cnt = 0, chnnl_skew = 0;
- fill_bank = 0, lcnt = rcnt = 0;
- host state EMPTY;
- read-delay pipeline flushed.
REQ-022 SHALL leave RAM contents undefined after reset; reset mid-read SHALL suppress any pending pcm_rd_valid.

Structure
REQ-023 SHALL place the host bank state enum and the frame-size localparams in shared package pcm_bffr_pkg.
REQ-024 SHALL instantiate one sub-module, pcm_dp_ram: a true dual-port synchronous RAM with MEM_RD_DEL read latency.

Verification
REQ-025 SHALL cover nominal fill: 128 left/right alternating samples, left value i, right value 0x1000+i -> pcm_rdy=1; read address 5 returns 5 and address 133 returns 0x1005, each valid 2 cycles after pcm_rden.
REQ-026 SHALL cover overflow: fill two frames without a host release -> second frame dropped, bffr_ovrflw pulses once, ovrflw_cnt=1, frame-1 data intact.
REQ-027 SHALL cover release: write address 255 -> pcm_rdy falls the next cycle; the next completed frame re-asserts pcm_rdy with new data at address 0.
REQ-028 SHALL cover skew: 129 left samples and 0 right -> chnnl_skew=1, no commit; then 128 right -> commit.
REQ-029 SHALL cover capture abort: capture_en dropped after 64 samples per channel, then 128 pairs -> frame holds only the post-abort data, starting at address 0.
REQ-030 SHALL cover collision: release and completion in the same cycle -> pcm_rdy stays 1, ovrflw_cnt unchanged.
